// File: rtl/img_scaler.sv
// ROM-to-framebuffer image scaler: copy, 2x/4x nearest-neighbour zoom or 2x decimation.
// One destination pixel is issued per clock; writes trail the ROM reads by ROM_LAT cycles.
module img_scaler #(
  parameter int SRC_W   = 160,
  parameter int SRC_H   = 120,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 19,
  parameter int DIM_W   = 10,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic [DIM_W-1:0]  dst_w,
  output logic [DIM_W-1:0]  dst_h
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [1:0] M_COPY = 2'd0;
  localparam logic [1:0] M_Z2   = 2'd1;
  localparam logic [1:0] M_Z4   = 2'd2;
  localparam int DRN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [DIM_W-1:0] W_X1  = DIM_W'(SRC_W);
  localparam logic [DIM_W-1:0] W_X2  = DIM_W'(2 * SRC_W);
  localparam logic [DIM_W-1:0] W_X4  = DIM_W'(4 * SRC_W);
  localparam logic [DIM_W-1:0] W_DEC = DIM_W'(SRC_W / 2);
  localparam logic [DIM_W-1:0] H_X1  = DIM_W'(SRC_H);
  localparam logic [DIM_W-1:0] H_X2  = DIM_W'(2 * SRC_H);
  localparam logic [DIM_W-1:0] H_X4  = DIM_W'(4 * SRC_H);
  localparam logic [DIM_W-1:0] H_DEC = DIM_W'(SRC_H / 2);
  localparam logic [ADDR_W-1:0] ROW1 = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] ROW2 = ADDR_W'(2 * SRC_W);

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [DIM_W-1:0]   dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [DIM_W-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic [ADDR_W-1:0]  src_base_q, src_base_d;
  logic [ADDR_W-1:0]  dst_addr_q, dst_addr_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               done_q, done_d;
  logic [PIX_W-1:0]   ram_data_q;
  logic               row_end, last_pix, drain_last, row_cross;
  logic [ADDR_W-1:0]  row_step;
  logic               wr_vld;
  logic [ADDR_W-1:0]  wr_addr;

  function automatic logic [ADDR_W-1:0] src_x(input logic [1:0] m, input logic [DIM_W-1:0] x);
    case (m)
      M_COPY:  return ADDR_W'(x);
      M_Z2:    return ADDR_W'(x >> 1);
      M_Z4:    return ADDR_W'(x >> 2);
      default: return ADDR_W'({x, 1'b0});
    endcase
  endfunction

  assign row_end    = (dx_q == dst_w_q - DIM_W'(1));
  assign last_pix   = row_end && (dy_q == dst_h_q - DIM_W'(1));
  assign drain_last = (drain_q == DRN_W'(ROM_LAT - 1));

  // Zoom rows share a source row until dy crosses a multiple of the factor.
  always_comb begin
    row_cross = 1'b1;
    row_step  = ROW1;
    case (mode_q)
      M_Z2:    row_cross = dy_q[0];
      M_Z4:    row_cross = &dy_q[1:0];
      M_COPY:  row_cross = 1'b1;
      default: row_step  = ROW2;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= M_COPY;
      dst_w_q    <= '0;
      dst_h_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      src_base_q <= '0;
      dst_addr_q <= '0;
      rom_addr_q <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dst_w_q    <= dst_w_d;
      dst_h_q    <= dst_h_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      src_base_q <= src_base_d;
      dst_addr_q <= dst_addr_d;
      rom_addr_q <= rom_addr_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      if (wr_vld) ram_data_q <= rom_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pix) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rom_addr always points at the pixel currently in RUN, so ROM data lines up ROM_LAT cycles later.
  always_comb begin
    mode_d     = mode_q;
    dst_w_d    = dst_w_q;
    dst_h_d    = dst_h_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    src_base_d = src_base_q;
    dst_addr_d = dst_addr_q;
    rom_addr_d = rom_addr_q;
    drain_d    = drain_q;
    done_d     = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = mode;
          done_d     = 1'b0;
          dx_d       = '0;
          dy_d       = '0;
          src_base_d = '0;
          dst_addr_d = '0;
          rom_addr_d = '0;
          case (mode)
            M_COPY:  begin dst_w_d = W_X1;  dst_h_d = H_X1;  end
            M_Z2:    begin dst_w_d = W_X2;  dst_h_d = H_X2;  end
            M_Z4:    begin dst_w_d = W_X4;  dst_h_d = H_X4;  end
            default: begin dst_w_d = W_DEC; dst_h_d = H_DEC; end
          endcase
        end
      end
      RUN: begin
        drain_d = '0;
        if (!last_pix) begin
          dst_addr_d = dst_addr_q + ADDR_W'(1);
          if (row_end) begin
            dx_d = '0;
            dy_d = dy_q + DIM_W'(1);
            if (row_cross) src_base_d = src_base_q + row_step;
          end else begin
            dx_d = dx_q + DIM_W'(1);
          end
          rom_addr_d = src_base_d + src_x(mode_q, dx_d);
        end
      end
      DRAIN: begin
        drain_d = drain_q + DRN_W'(1);
        if (drain_last) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Destination address and valid travel alongside the ROM read latency.
  for (genvar gi = 0; gi < ROM_LAT; gi++) begin : stage
    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q  <= 1'b0;
          addr_q <= '0;
        end else begin
          vld_q <= (state_q == RUN);
          if (state_q == RUN) addr_q <= dst_addr_q;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q  <= 1'b0;
          addr_q <= '0;
        end else begin
          vld_q <= stage[gi-1].vld_q;
          if (stage[gi-1].vld_q) addr_q <= stage[gi-1].addr_q;
        end
      end
    end
  end

  assign wr_vld  = stage[ROM_LAT-1].vld_q;
  assign wr_addr = stage[ROM_LAT-1].addr_q;

  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    rom_addr = rom_addr_q;
    ram_wren = wr_vld;
    ram_addr = wr_addr;
    ram_data = wr_vld ? rom_data : ram_data_q;
    dst_w    = dst_w_q;
    dst_h    = dst_h_q;
  end

endmodule

// File: tb/tb_img_scaler.sv
// Bench for img_scaler: 4x2 source, ROM content equals its address, writes checked against a reference image.
module tb_img_scaler;
  localparam int SW = 4;
  localparam int SH = 2;
  localparam int PW = 8;
  localparam int AW = 19;
  localparam int DW = 10;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          busy, done, ram_wren;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [PW-1:0] rom_data = '0;
  logic [PW-1:0] ram_data;
  logic [DW-1:0] dst_w, dst_h;

  int total = 0;
  int bad = 0;
  int wr_a[$];
  int wr_d[$];
  int exp_a[$];
  int exp_d[$];
  int fb[256];

  img_scaler #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .ADDR_W(AW), .DIM_W(DW), .ROM_LAT(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .dst_w(dst_w), .dst_h(dst_h)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle of latency, content = address.
  always @(posedge clk) rom_data <= rom_addr[PW-1:0];

  // Framebuffer observer.
  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      wr_a.push_back(int'(ram_addr));
      wr_d.push_back(int'(ram_data));
      if (ram_addr < AW'(256)) fb[ram_addr[7:0]] = int'(ram_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dim_w(input int m);
    case (m)
      0: return SW;
      1: return 2 * SW;
      2: return 4 * SW;
      default: return SW / 2;
    endcase
  endfunction

  function automatic int dim_h(input int m);
    case (m)
      0: return SH;
      1: return 2 * SH;
      2: return 4 * SH;
      default: return SH / 2;
    endcase
  endfunction

  // Reference image: every destination pixel maps straight to its nearest source pixel.
  task automatic build_model(input int m, input int reps);
    int dw, dh, sx, sy;
    exp_a.delete();
    exp_d.delete();
    dw = dim_w(m);
    dh = dim_h(m);
    for (int r = 0; r < reps; r++)
      for (int y = 0; y < dh; y++)
        for (int x = 0; x < dw; x++) begin
          case (m)
            0: begin sx = x;     sy = y;     end
            1: begin sx = x / 2; sy = y / 2; end
            2: begin sx = x / 4; sy = y / 4; end
            default: begin sx = 2 * x; sy = 2 * y; end
          endcase
          exp_a.push_back(y * dw + x);
          exp_d.push_back((sy * SW + sx) % 256);
        end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk($sformatf("%s_nwr", tag), wr_a.size(), exp_a.size());
    n = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr[%0d]", tag, i), wr_a[i], exp_a[i]);
      chk($sformatf("%s_data[%0d]", tag, i), wr_d[i], exp_d[i]);
    end
  endtask

  task automatic run_mode(input logic [1:0] m, input bit disturb);
    int busy_cyc, done_during, n;
    string tag;
    tag = $sformatf("m%0d%s", m, disturb ? "d" : "");
    wr_a.delete();
    wr_d.delete();
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    done_during = 0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      busy_cyc++;
      if (done === 1'b1) done_during++;
      if (disturb && busy_cyc == 6) begin
        mode  = m ^ 2'b11;
        start = 1'b1;
      end else if (disturb && busy_cyc == 7) begin
        mode  = 2'($urandom_range(0, 3));
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_timeout"}, n < 2000, 1);
    chk({tag, "_busy_cyc"}, busy_cyc, dim_w(int'(m)) * dim_h(int'(m)) + RL);
    chk({tag, "_dst_w"}, dst_w, dim_w(int'(m)));
    chk({tag, "_dst_h"}, dst_h, dim_h(int'(m)));
    chk({tag, "_done_end"}, done, 1);
    chk({tag, "_done_while_busy"}, done_during, 0);
    build_model(int'(m), 1);
    compare_writes(tag);
    $display("run mode=%0d disturb=%0d busy=%0d writes=%0d", m, disturb, busy_cyc, wr_a.size());
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic reset_midrun();
    int nbefore;
    wr_a.delete();
    wr_d.delete();
    mode  = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_wren", ram_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    nbefore = wr_a.size();
    chk("rst_pre_writes", nbefore, 10);
    repeat (3) @(negedge clk);
    chk("rst_no_writes", wr_a.size(), nbefore);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_dst_w", dst_w, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_no_resume", busy, 0);
    $display("reset mid-run: writes before reset=%0d", nbefore);
  endtask

  task automatic start_held();
    int rises, falls, busy_cnt, done_cnt, n;
    logic prev_busy;
    wr_a.delete();
    wr_d.delete();
    mode = 2'd0;
    start = 1'b1;
    rises = 0; falls = 0; busy_cnt = 0; done_cnt = 0; n = 0;
    prev_busy = 1'b0;
    while (falls < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy && !prev_busy) rises++;
      if (!busy && prev_busy) falls++;
      if (busy) busy_cnt++;
      if (done && falls < 2) done_cnt++;
      if (rises == 2) start = 1'b0;
      prev_busy = busy;
    end
    start = 1'b0;
    chk("held_timeout", n < 200, 1);
    chk("held_busy_cyc", busy_cnt, 2 * (SW * SH + RL));
    chk("held_done_cyc", done_cnt, 1);
    chk("held_done_end", done, 1);
    build_model(0, 2);
    compare_writes("held");
    $display("start held: runs=%0d busy=%0d done_cycles=%0d writes=%0d", rises, busy_cnt, done_cnt, wr_a.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) fb[i] = -1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wren", ram_wren, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_ram_data", ram_data, 0);
    chk("reset_dst_w", dst_w, 0);
    chk("reset_dst_h", dst_h, 0);
    rst = 1'b1;
    @(negedge clk);

    run_mode(2'd0, 1'b0);
    run_mode(2'd1, 1'b0);
    chk("z2_fb9", fb[9], 0);
    chk("z2_fb10", fb[10], 1);
    chk("z2_fb16", fb[16], 4);
    chk("z2_fb31", fb[31], 7);
    run_mode(2'd2, 1'b0);
    chk("z4_fb20", fb[20], 1);
    chk("z4_fb67", fb[67], 4);
    chk("z4_fb127", fb[127], 7);
    run_mode(2'd3, 1'b0);
    chk("dec_fb0", fb[0], 0);
    chk("dec_fb1", fb[1], 2);

    run_mode(2'd1, 1'b1);
    reset_midrun();
    run_mode(2'd0, 1'b0);
    start_held();
    @(negedge clk);

    for (int k = 0; k < 4; k++)
      run_mode(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_scaler.md
Name: img_scaler

Overview:
- Parametrised ROM-to-framebuffer image scaler; the next generation of the fixed 2x pixel-replication copier.
- Reads a SRC_W x SRC_H source image from a synchronous ROM and writes a scaled copy, row-major from address 0, into a single-port framebuffer RAM.
- Run-time mode: 1x copy, 2x or 4x nearest-neighbour zoom, or 2x decimation.
- Sits between the image ROM and the framebuffer. The top level muxes the RAM address between this block (busy) and the VGA reader (done), and centres the image using dst_w/dst_h.

Parameters:
- SRC_W, 160, source width in pixels
- SRC_H, 120, source height in pixels
- PIX_W, 8, pixel width in bits
- ADDR_W, 19, ROM/RAM address width; must hold SRC_W*SRC_H*16
- DIM_W, 10, width of the dimension outputs
- ROM_LAT, 1, cycles from rom_addr to valid rom_data (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  level; sampled only in IDLE
- mode  in  2  00 copy, 01 zoom 2x, 10 zoom 4x, 11 decimate 2x; latched on start
- busy  out  1  high from the accepted start until the last RAM write
- done  out  1  sticky; set after the last write, cleared by the next accepted start
- rom_addr  out  ADDR_W  source read address
- rom_data  in  PIX_W  source pixel
- ram_addr  out  ADDR_W  framebuffer write address
- ram_data  out  PIX_W  framebuffer write data
- ram_wren  out  1  write strobe
- dst_w  out  DIM_W  destination width for the latched mode
- dst_h  out  DIM_W  destination height for the latched mode

Behaviour:
- Reset (rst=0) values, applied immediately: state IDLE; busy=0; done=0; ram_wren=0; rom_addr=0; ram_addr=0; ram_data=0; dst_w=0; dst_h=0; write pipeline valid bits cleared.
- Reset mid-run aborts with no further writes. No resume: the next start begins again at address 0.
- Destination size:
  - copy: SRC_W x SRC_H
  - zoom 2x: 2*SRC_W x 2*SRC_H
  - zoom 4x: 4*SRC_W x 4*SRC_H
  - decimate: floor(SRC_W/2) x floor(SRC_H/2)
- dst_w/dst_h update on the clock that accepts start and hold until the next accepted start.
- States IDLE, RUN, DRAIN.
  - IDLE -> RUN when start=1. That edge latches mode, clears done, sets busy, and sets dx=dy=0.
  - RUN: one destination pixel issued per clock, dx fastest. dx wraps to 0 at dst_w-1 and dy increments.
  - After issuing (dst_w-1, dst_h-1): RUN -> DRAIN.
  - DRAIN lasts exactly ROM_LAT cycles. On its exit edge, busy=0 and done=1, and the state returns to IDLE.
  - start and mode are ignored outside IDLE.
  - If start is held high, a new run is accepted on the first IDLE cycle, so done is high for one cycle.
- Source coordinate for destination (dx, dy):
  - copy: (dx, dy)
  - zoom 2x: (dx>>1, dy>>1)
  - zoom 4x: (dx>>2, dy>>2)
  - decimate: (2dx, 2dy)
- Addresses:
  - rom_addr = sy*SRC_W + sx
  - destination address = dy*dst_w + dx
  - Both are produced by incremental row-base accumulators; no multipliers.
  - A zoom row reuses its source row base until dy crosses a factor boundary.
- Pipeline: rom_addr is registered in the issue cycle. The destination address and a valid bit are delayed ROM_LAT cycles. In the cycle where the delayed valid is 1, ram_wren=1, ram_addr=delayed address and ram_data=rom_data.
- Throughput one write per clock, no gaps. Total busy cycles = dst_w*dst_h + ROM_LAT.
- Outside writes: ram_wren=0. ram_addr/ram_data hold their last values.
- rom_addr holds its last value in IDLE.

Test Plan:
Bench settings: SRC_W=4, SRC_H=2, ROM_LAT=1, ROM content = address value.
- Copy: start pulse with mode=00 -> dst_w=4, dst_h=2; 8 consecutive writes, addr 0..7 with data 0..7; busy high 9 cycles; done rises with busy fall.
- Zoom 2x: mode=01 -> dst 8x4, 32 writes. Checks: addr 9 data 0, addr 10 data 1, addr 16 data 4, addr 31 data 7.
- Zoom 4x: mode=10 -> dst 16x8, 128 writes. Checks: addr 20 data 1, addr 67 data 4, addr 127 data 7; busy 129 cycles.
- Decimate: mode=11 -> dst 2x1; exactly 2 writes: addr 0 data 0, addr 1 data 2.
- Control robustness, run in mode 01:
  - Pulse start and toggle mode mid-run -> ignored; still 32 writes.
  - Assert rst low mid-run -> ram_wren, busy and done go 0 before the next clk edge; no writes while low.
  - After release, start with mode=00 -> writes begin at addr 0.
- start held high through completion -> done high exactly 1 cycle, then a second identical 8-write run follows.
